// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types: register file geometry,
// the hard-wired $zero index and the longest supported load latency.
package mips_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 1 << REG_ADDR_W;
  localparam int MAX_LOAD_LAT = 7;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  // Bits needed to hold a countdown from lat down to zero.
  function automatic int timer_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/load_timer.sv
// Per-register load countdown: reloads on load, otherwise counts down to zero.
// busy is high while the loaded value has not yet become forwardable.
module load_timer
  import mips_pkg::*;
#(
  parameter int W = timer_width(MAX_LOAD_LAT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A fresh load wins over the decrement so back-to-back loads restart the wait.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit beside ID: per-register load timers, stall/bubble
// generation for readers of pending registers, and a saturating stall counter.
module load_hazard_scoreboard #(
  parameter int NUM_REGS   = mips_pkg::NUM_REGS,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  output logic                  stall,
  output logic                  bubble,
  output logic [NUM_REGS-1:0]   pending,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int TW = mips_pkg::timer_width(LOAD_LAT);
  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(mips_pkg::ZERO_REG);

  logic [NUM_REGS-1:0] busy;
  logic                haz_rs;
  logic                haz_rt;
  logic                stall_int;
  logic                issue;
  logic                ld_en;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    stall_cnt_d;

  assign haz_rs = id_rs_used && (id_rs != ZERO) && busy[id_rs];
  assign haz_rt = id_rt_used && (id_rt != ZERO) && busy[id_rt];

  // Reset masks the stall so a pipeline being reset never sees a held PC.
  assign stall_int = !rst && id_valid && !flush && (haz_rs || haz_rt);
  assign stall     = stall_int;
  assign bubble    = stall_int;

  assign issue = id_valid && !stall_int && !flush;
  assign ld_en = issue && id_mem_read && (id_rd != ZERO);

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_timer
    load_timer #(
      .W(TW)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (ld_en && (id_rd == REG_ADDR_W'(r))),
      .load_val(TW'(LOAD_LAT)),
      .busy    (busy[r])
    );
  end

  assign pending = busy;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_int && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Three scoreboards (load latency 1, 2 and 3; the last with a 4-bit counter)
// share one instruction stream and are compared against a timestamp model.
module tb_load_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic       id_mem_read;
  logic [4:0] id_rd;
  logic       flush;

  logic        stall_o  [3];
  logic        bubble_o [3];
  logic [31:0] pend_o   [3];
  logic [15:0] sc0;
  logic [15:0] sc1;
  logic [3:0]  sc2;

  load_hazard_scoreboard #(.LOAD_LAT(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_mem_read(id_mem_read),
    .id_rd(id_rd), .flush(flush), .stall(stall_o[0]), .bubble(bubble_o[0]),
    .pending(pend_o[0]), .stall_count(sc0));

  load_hazard_scoreboard #(.LOAD_LAT(2), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_mem_read(id_mem_read),
    .id_rd(id_rd), .flush(flush), .stall(stall_o[1]), .bubble(bubble_o[1]),
    .pending(pend_o[1]), .stall_count(sc1));

  load_hazard_scoreboard #(.LOAD_LAT(3), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_mem_read(id_mem_read),
    .id_rd(id_rd), .flush(flush), .stall(stall_o[2]), .bubble(bubble_o[2]),
    .pending(pend_o[2]), .stall_count(sc2));

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lat  [3] = '{1, 2, 3};
  int smax [3] = '{65535, 65535, 15};
  int iss  [3][32];
  int msc  [3];

  // Reference: a register is pending from 1 to LOAD_LAT cycles after its last load issued.
  function automatic bit mpend(input int i, input int r);
    int age;
    age = cyc - iss[i][r];
    return (r != 0) && (age >= 1) && (age <= lat[i]);
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      msc[i] = 0;
      for (int r = 0; r < 32; r++) iss[i][r] = -100;
    end
  endtask

  function automatic logic [31:0] sc_of(input int i);
    if (i == 0) return {16'b0, sc0};
    if (i == 1) return {16'b0, sc1};
    return {28'b0, sc2};
  endfunction

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic rsu, input logic rtu, input logic mr,
                      input logic [4:0] rd, input logic fl, input logic r);
    logic [31:0] ep;
    bit          es;
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_mem_read = mr; id_rd = rd; flush = fl; rst = r;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ep = '0;
      for (int k = 0; k < 32; k++) ep[k] = mpend(i, k);
      es = !r && v && !fl && ((rsu && mpend(i, int'(rs))) || (rtu && mpend(i, int'(rt))));
      chk("stall", i, {31'b0, stall_o[i]}, {31'b0, es});
      chk("bubble", i, {31'b0, bubble_o[i]}, {31'b0, es});
      chk("pending", i, pend_o[i], ep);
      chk("stall_count", i, sc_of(i), msc[i]);
      if (!r) begin
        if (es && msc[i] < smax[i]) msc[i]++;
        if (v && !es && !fl && mr && rd != 0) iss[i][rd] = cyc;
      end
    end
    if (r) model_reset();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0;
    id_rt_used = 0; id_mem_read = 0; id_rd = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    // reset state, then idle
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // single-bubble: lw $5 then add reading $5
    step(1, 0, 0, 0, 0, 1, 5, 0, 0);
    repeat (4) step(1, 5, 3, 1, 1, 0, 8, 0, 0);
    // longer latency: dependent on rt=7 two cycles after the load
    step(1, 0, 0, 0, 0, 1, 7, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 7, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 7, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    repeat (2) step(1, 0, 7, 0, 0, 0, 0, 0, 0);
    // load to $zero then readers of $zero
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 1, 1, 0, 0, 0, 0);
    // flushed dependent load must not stall or arm $10
    step(1, 0, 0, 0, 0, 1, 9, 0, 0);
    step(1, 9, 0, 1, 0, 1, 10, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // back-to-back loads to $4
    step(1, 0, 0, 0, 0, 1, 4, 0, 0);
    step(1, 0, 0, 0, 0, 1, 4, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a stall
    step(1, 0, 0, 0, 0, 1, 6, 0, 0);
    step(1, 6, 0, 1, 0, 0, 0, 0, 0);
    step(1, 6, 0, 1, 0, 0, 0, 0, 1);
    step(1, 6, 0, 1, 0, 0, 0, 0, 0);
    chk("post_rst_sc", 2, {28'b0, sc2}, 32'd0);
    chk("post_rst_pend", 2, pend_o[2], 32'd0);
    // saturation: eight load/dependent rounds
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 8; n++) begin
      step(1, 0, 0, 0, 0, 1, 7, 0, 0);
      repeat (4) step(1, 7, 0, 1, 0, 0, 0, 0, 0);
    end
    chk("sat_lat1", 0, {16'b0, sc0}, 32'd8);
    chk("sat_lat2", 1, {16'b0, sc1}, 32'd16);
    chk("sat_lat3", 2, {28'b0, sc2}, 32'd15);
    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 5) != 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 59) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_hazard_scoreboard.md
# load_hazard_scoreboard

Parametrised load-use hazard unit for the 5-stage MIPS pipeline. It sits beside the ID stage and tracks every in-flight load with a per-register countdown timer. It stalls the instruction in ID until each source register it reads can be forwarded, and injects one bubble into ID/EX per stall cycle. It supports load latencies above one cycle, ignores `$zero`, honours per-operand use flags, survives flushes, and keeps a saturating stall-cycle counter.

## Interface
- `NUM_REGS`, 32: architectural registers tracked.
- `REG_ADDR_W`, 5: register index width; `2**REG_ADDR_W == NUM_REGS`.
- `LOAD_LAT`, 1: cycles after issue before load data is forwardable, legal 1..7.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs` in `REG_ADDR_W`: source register A.
- `id_rt` in `REG_ADDR_W`: source register B.
- `id_rs_used` in 1: the instruction reads rs.
- `id_rt_used` in 1: the instruction reads rt.
- `id_mem_read` in 1: the ID instruction is a load.
- `id_rd` in `REG_ADDR_W`: load destination register.
- `flush` in 1: the ID instruction is killed this cycle (taken branch or jump).
- `stall` out 1: hold PC and IF/ID.
- `bubble` out 1: force ID/EX control signals to NOP.
- `pending` out `NUM_REGS`: bit r set when `cnt[r] != 0`.
- `stall_count` out `CNT_W`: saturating count of stall cycles.

## Operation
- **State**
  - `cnt[r]`: `ceil(log2(LOAD_LAT+1))` bits per register.
  - `stall_count`.
- **Hazard**: `haz_rs = id_rs_used && id_rs != 0 && cnt[id_rs] != 0`; `haz_rt` likewise.
- **Stall**: `stall = id_valid && !flush && (haz_rs || haz_rt)`. `bubble = stall`. Both are combinational.
- **Issue**: `issue = id_valid && !stall && !flush`.
- **Timer load**: if `issue && id_mem_read && id_rd != 0`, then `cnt[id_rd] <= LOAD_LAT` next edge.
- **Timer decrement**: every other nonzero `cnt[r] <= cnt[r] - 1`. The issue load takes priority over the decrement on the same register.
- **Self-dependence**: a load that depends on a pending register stalls like any other instruction. Its own timer loads only when it issues.
- **Back-to-back loads** to the same rd: the later issue reloads the timer to `LOAD_LAT`.
- **Flush**: the ID instruction neither stalls nor issues. Existing timers keep counting, because loads already past ID still complete.
- **`$zero`**: `cnt[0]` is held at 0 permanently and never causes a stall.
- **Stall counter**: `stall_count` increments on each cycle with `stall=1`. It saturates at `2**CNT_W-1` and does not wrap.
- **Reset**: all `cnt` go to 0, `stall_count` goes to 0, `pending` reads 0. `stall` and `bubble` are 0 during reset regardless of inputs.

## Timing
- Latency from load issue to `pending` set is 1 edge.
- A load issued at cycle t with dependent instruction in ID at t+1:
  - `stall` is high in cycles t+1 .. t+LOAD_LAT.
  - The dependent instruction issues at t+LOAD_LAT+1.
- With `LOAD_LAT=1` this gives exactly one bubble, matching the classic single-bubble load-use behaviour.
- A dependent instruction arriving k cycles after the load stalls for `max(0, LOAD_LAT-k+1)` cycles.
- Reset asserted mid-stall clears all timers on the next edge. The following cycle does not stall.

## Structure
- Shared package `mips_pkg`:
  - `REG_ADDR_W`, `NUM_REGS`.
  - `ZERO_REG = 0`.
  - `reg_addr_t` typedef.
  - Maximum `LOAD_LAT` constant.
- One sub-module `load_timer`: a single per-register down-counter with `load`, `load_val`, `busy` out and synchronous reset. It is instantiated `NUM_REGS-1` times via generate (index 0 tied off).
- The top level holds the hazard compare, issue logic and stall counter.

## Test plan
- **Single-bubble case**: `LOAD_LAT=1`, `lw $5` issues at t, `add` reading rs=5 in ID at t+1 → `stall=bubble=1` for 1 cycle, issue at t+2, `stall_count=1`.
- **Longer latency**: `LOAD_LAT=3`, load to $7, dependent on rt=7 with `rt_used=1` at t+2 → stalls 2 cycles. The same instruction with `rt_used=0` → no stall.
- **`$zero` destination**: load to `$0` followed by a reader of `$0` → no stall, `pending[0]=0`.
- **Flush**: load to $9 issues; next cycle a dependent instruction arrives with `flush=1` → `stall=0`, no timer load. `pending[9]` still clears after `LOAD_LAT` cycles.
- **Reload and reset**: two loads to $4 issued 1 cycle apart with `LOAD_LAT=2` → `pending[4]` stays high 3 cycles total. `rst` asserted mid-stall → next cycle `pending=0`, `stall=0`, `stall_count=0`.
- **Counter saturation**: `CNT_W=4` with a dependent instruction held stalled 20 cycles (repeated loads) → `stall_count` stops at 15.
